// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: shared FSM encoding, port ids, ROM geometry and ROM image
package rom_port_arbiter_pkg;
   localparam int ROM_AW = 8;
   localparam int ROM_DW = 8;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ_IF = 2'd1,
      ST_READ_DT = 2'd2
   } state_t;
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DT = 1'b1;
   // Program image: each word is its address XOR 8'h5A.
   function automatic logic [ROM_DW-1:0] rom_image(input logic [ROM_AW-1:0] a);
      return a ^ 8'h5A;
   endfunction
endpackage

// File: rtl/rom_8x256.sv
// rom_8x256: asynchronous 256x8 program/data ROM
module rom_8x256
   import rom_port_arbiter_pkg::*;
(
   input  logic [ROM_AW-1:0] i_addr,
   output logic [ROM_DW-1:0] o_data
);
   assign o_data = rom_image(i_addr);
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of one async ROM between fetch and data-table readers
module rom_port_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter bit IF_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ROM_AW-1:0] if_addr,
   output logic              if_ack,
   output logic [ROM_DW-1:0] if_data,
   input  logic              dt_req,
   input  logic [ROM_AW-1:0] dt_addr,
   output logic              dt_ack,
   output logic [ROM_DW-1:0] dt_data,
   output logic              busy
);
   state_t            r_state;
   state_t            w_state_nx;
   logic              r_last;
   logic [ROM_AW-1:0] r_addr_q;
   logic              r_if_ack;
   logic              r_dt_ack;
   logic [ROM_DW-1:0] r_if_data;
   logic [ROM_DW-1:0] r_dt_data;
   logic [ROM_DW-1:0] w_rom_data;
   logic              w_elig_if;
   logic              w_elig_dt;
   logic              w_grant_if;
   logic              w_grant_dt;

   rom_8x256 u_rom (
      .i_addr (r_addr_q),
      .o_data (w_rom_data)
   );

   // A port is blocked in its own READ cycle and its own ack cycle; ties go away from r_last.
   always_comb begin
      w_elig_if  = if_req & ~r_if_ack & (r_state != ST_READ_IF);
      w_elig_dt  = dt_req & ~r_dt_ack & (r_state != ST_READ_DT);
      w_grant_if = w_elig_if & (~w_elig_dt | (r_last == PORT_DT));
      w_grant_dt = w_elig_dt & ~w_grant_if;
      w_state_nx = w_grant_if ? ST_READ_IF : w_grant_dt ? ST_READ_DT : ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_last    <= IF_FIRST ? PORT_DT : PORT_IF;
         r_addr_q  <= '0;
         r_if_ack  <= 1'b0;
         r_dt_ack  <= 1'b0;
         r_if_data <= '0;
         r_dt_data <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_if_ack <= (r_state == ST_READ_IF);
         r_dt_ack <= (r_state == ST_READ_DT);
         if (r_state == ST_READ_IF) r_if_data <= w_rom_data;
         if (r_state == ST_READ_DT) r_dt_data <= w_rom_data;
         if (w_grant_if | w_grant_dt) begin
            r_addr_q <= w_grant_if ? if_addr : dt_addr;
            r_last   <= w_grant_if ? PORT_IF : PORT_DT;
         end
      end
   end

   assign if_ack  = r_if_ack;
   assign dt_ack  = r_dt_ack;
   assign if_data = r_if_data;
   assign dt_data = r_dt_data;
   assign busy    = (r_state != ST_IDLE);
endmodule
